medidor_echo_bcd: RTL and testbench



---
 rtl/medidor_pkg.sv | 25 ++
 rtl/medidor_echo_bcd_contador.sv | 57 +++++
 rtl/medidor_echo_bcd.sv | 153 +++++++++++++++
 tb/tb_medidor_echo_bcd.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/medidor_pkg.sv
// Shared definitions for the echo-to-BCD distance meter: FSM state codes
// and the BCD digit helper used by the saturating counter.
package medidor_pkg;

  typedef enum logic [3:0] {
    st_inicial   = 4'd0,
    st_espera    = 4'd1,
    st_conta     = 4'd2,
    st_arredonda = 4'd3,
    st_armazena  = 4'd4,
    st_final     = 4'd5
  } estado_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Returns {carry_out, next_digit} for a single BCD digit increment.
  function automatic logic [4:0] bcd_inc(input logic [3:0] digit);
    if (digit == BCD_MAX) begin
      return {1'b1, 4'd0};
    end else begin
      return {1'b0, digit + 4'd1};
    end
  endfunction

endpackage

// File: rtl/medidor_echo_bcd_contador.sv
// Three-digit BCD up-counter that sticks at 999 and flags any increment
// attempted beyond it.
module contador_bcd_3dig
  import medidor_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        zera,
  input  logic        conta,
  output logic [11:0] Q,
  output logic        sat
);

  logic [11:0] q_r;
  logic        sat_r;
  logic [4:0]  uni_inc_s;
  logic [4:0]  dez_inc_s;
  logic [4:0]  cen_inc_s;
  logic [11:0] q_next_s;

  // Ripple the carry through the three digits.
  always_comb begin
    uni_inc_s = bcd_inc(q_r[3:0]);
    if (uni_inc_s[4]) begin
      dez_inc_s = bcd_inc(q_r[7:4]);
    end else begin
      dez_inc_s = {1'b0, q_r[7:4]};
    end
    if (dez_inc_s[4]) begin
      cen_inc_s = bcd_inc(q_r[11:8]);
    end else begin
      cen_inc_s = {1'b0, q_r[11:8]};
    end
    q_next_s = {cen_inc_s[3:0], dez_inc_s[3:0], uni_inc_s[3:0]};
  end

  // Counter and saturation flag; a carry out of the hundreds means 999 was hit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_r   <= 12'h000;
      sat_r <= 1'b0;
    end else if (zera) begin
      q_r   <= 12'h000;
      sat_r <= 1'b0;
    end else if (conta) begin
      if (cen_inc_s[4]) begin
        sat_r <= 1'b1;
      end else begin
        q_r <= q_next_s;
      end
    end
  end

  assign Q   = q_r;
  assign sat = sat_r;

endmodule

// File: rtl/medidor_echo_bcd.sv
// Measures the HC-SR04 echo pulse width and reports it as 3-digit BCD
// centimetres, rounded to the nearest unit, with a one-cycle pronto strobe.
module medidor_echo_bcd
  import medidor_pkg::*;
#(
  parameter int R  = 2941,
  parameter int RW = $clog2(R)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        zera,
  input  logic        echo,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        estouro,
  output logic [3:0]  db_estado
);

  localparam logic [RW-1:0] TICK_MAX  = RW'(R - 1);
  localparam logic [RW-1:0] TICK_HALF = RW'(R / 2);

  logic          echo_meta_r;
  logic          echo_s_r;
  estado_t       state_r;
  estado_t       state_next_s;
  logic [RW-1:0] tick_r;
  logic [RW-1:0] tick_next_s;
  logic          bcd_clr_s;
  logic          bcd_inc_s;
  logic          medida_ld_s;
  logic [11:0]   bcd_q_s;
  logic          bcd_sat_s;
  logic [11:0]   medida_r;
  logic          estouro_r;
  logic          pronto_r;

  // Two-flop synchroniser for the asynchronous echo pin.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_meta_r <= 1'b0;
      echo_s_r    <= 1'b0;
    end else begin
      echo_meta_r <= echo;
      echo_s_r    <= echo_meta_r;
    end
  end

  // Next-state and tick logic; zera overrides every transition.
  always_comb begin
    state_next_s = state_r;
    tick_next_s  = tick_r;
    bcd_clr_s    = 1'b0;
    bcd_inc_s    = 1'b0;
    medida_ld_s  = 1'b0;
    case (state_r)
      st_inicial: begin
        tick_next_s  = '0;
        bcd_clr_s    = 1'b1;
        state_next_s = st_espera;
      end
      st_espera: begin
        if (echo_s_r) begin
          tick_next_s  = RW'(1);
          state_next_s = st_conta;
        end else begin
          state_next_s = st_espera;
        end
      end
      st_conta: begin
        if (echo_s_r) begin
          if (tick_r == TICK_MAX) begin
            tick_next_s = '0;
            bcd_inc_s   = 1'b1;
          end else begin
            tick_next_s = tick_r + RW'(1);
          end
        end else begin
          state_next_s = st_arredonda;
        end
      end
      st_arredonda: begin
        // Round half up, but never push past 999.
        if ((tick_r >= TICK_HALF) && (bcd_q_s != 12'h999)) begin
          bcd_inc_s = 1'b1;
        end else begin
          bcd_inc_s = 1'b0;
        end
        state_next_s = st_armazena;
      end
      st_armazena: begin
        medida_ld_s  = 1'b1;
        state_next_s = st_final;
      end
      st_final: begin
        state_next_s = st_inicial;
      end
      default: begin
        tick_next_s  = '0;
        state_next_s = st_inicial;
      end
    endcase
    if (zera) begin
      state_next_s = st_inicial;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // State and tick registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= st_inicial;
      tick_r  <= '0;
    end else begin
      state_r <= state_next_s;
      tick_r  <= tick_next_s;
    end
  end

  // Result registers; pronto is raised on the edge that enters st_final.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      medida_r  <= 12'h000;
      estouro_r <= 1'b0;
      pronto_r  <= 1'b0;
    end else if (zera) begin
      medida_r  <= 12'h000;
      estouro_r <= 1'b0;
      pronto_r  <= 1'b0;
    end else begin
      pronto_r <= medida_ld_s;
      if (medida_ld_s) begin
        medida_r  <= bcd_q_s;
        estouro_r <= bcd_sat_s;
      end
    end
  end

  contador_bcd_3dig u_contador (
    .clock (clock),
    .reset (reset),
    .zera  (zera | bcd_clr_s),
    .conta (bcd_inc_s),
    .Q     (bcd_q_s),
    .sat   (bcd_sat_s)
  );

  assign medida    = medida_r;
  assign estouro   = estouro_r;
  assign pronto    = pronto_r;
  assign db_estado = state_r;

endmodule

// File: tb/tb_medidor_echo_bcd.sv
// Directed bench for medidor_echo_bcd with R=10: a vector table of pulse
// widths plus hand-written zera, back-to-back and async-reset sequences.
module tb_medidor_echo_bcd;

  localparam int R = 10;

  logic        clock = 1'b0;
  logic        reset;
  logic        zera;
  logic        echo;
  logic [11:0] medida;
  logic        pronto;
  logic        estouro;
  logic [3:0]  db_estado;

  int errors     = 0;
  int checks     = 0;
  int pronto_cnt = 0;

  typedef struct {
    int          high;
    logic [11:0] exp_medida;
    logic        exp_estouro;
  } vec_t;

  vec_t vecs[9];

  always #5 clock = ~clock;

  // Count pronto cycles shortly after each rising edge.
  always @(posedge clock) begin
    #1;
    if (pronto === 1'b1) pronto_cnt++;
  end

  medidor_echo_bcd #(.R(R)) dut (
    .clock     (clock),
    .reset     (reset),
    .zera      (zera),
    .echo      (echo),
    .medida    (medida),
    .pronto    (pronto),
    .estouro   (estouro),
    .db_estado (db_estado)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input int n);
    @(negedge clock);
    echo = 1'b1;
    repeat (n) @(negedge clock);
    echo = 1'b0;
  endtask

  // Negedges from the echo drop until pronto is first seen; -1 on timeout.
  task automatic wait_pronto(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (pronto === 1'b1 && lat < 0) lat = k;
    end
  endtask

  initial begin
    int lat;
    int base;

    vecs[0] = '{25,    12'h003, 1'b0};
    vecs[1] = '{24,    12'h002, 1'b0};
    vecs[2] = '{1095,  12'h110, 1'b0};
    vecs[3] = '{100,   12'h010, 1'b0};
    vecs[4] = '{4,     12'h000, 1'b0};
    vecs[5] = '{15,    12'h002, 1'b0};
    vecs[6] = '{12000, 12'h999, 1'b1};
    vecs[7] = '{30,    12'h003, 1'b0};
    vecs[8] = '{9994,  12'h999, 1'b0};

    reset = 1'b1;
    zera  = 1'b0;
    echo  = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_medida", 32'(medida), 32'h000);
    check("reset_pronto", 32'(pronto), 32'h0);
    check("reset_estouro", 32'(estouro), 32'h0);
    check("reset_estado", 32'(db_estado), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("idle_estado", 32'(db_estado), 32'h1);

    for (int i = 0; i < 9; i++) begin
      base = pronto_cnt;
      pulse(vecs[i].high);
      wait_pronto(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd5);
      check($sformatf("v%0d_pronto_count", i), 32'(pronto_cnt - base), 32'd1);
      check($sformatf("v%0d_medida", i), 32'(medida), 32'(vecs[i].exp_medida));
      check($sformatf("v%0d_estouro", i), 32'(estouro), 32'(vecs[i].exp_estouro));
    end

    // Restore a nonzero medida before the zera test.
    pulse(30);
    wait_pronto(lat);
    check("pre_zera_medida", 32'(medida), 32'h003);

    // zera after 10 high cycles of a 50-cycle pulse; remainder is 40 cycles.
    base = pronto_cnt;
    @(negedge clock);
    echo = 1'b1;
    repeat (10) @(negedge clock);
    zera = 1'b1;
    @(negedge clock);
    zera = 1'b0;
    check("zera_medida", 32'(medida), 32'h000);
    check("zera_estouro", 32'(estouro), 32'h0);
    check("zera_estado", 32'(db_estado), 32'h0);
    repeat (39) @(negedge clock);
    echo = 1'b0;
    check("zera_no_pronto", 32'(pronto_cnt - base), 32'd0);
    wait_pronto(lat);
    check("zera_rest_latency", 32'(lat), 32'd5);
    check("zera_rest_medida", 32'(medida), 32'h004);
    check("zera_rest_count", 32'(pronto_cnt - base), 32'd1);

    // 30 high, 5 low, 40 high: second pulse starts in the pronto cycle.
    base = pronto_cnt;
    pulse(30);
    lat = -1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (pronto === 1'b1 && lat < 0) lat = k;
    end
    check("pair1_latency", 32'(lat), 32'd5);
    check("pair1_medida", 32'(medida), 32'h003);
    echo = 1'b1;
    repeat (40) @(negedge clock);
    echo = 1'b0;
    wait_pronto(lat);
    check("pair2_latency", 32'(lat), 32'd5);
    check("pair2_medida", 32'(medida), 32'h004);
    check("pair_count", 32'(pronto_cnt - base), 32'd2);

    // Asynchronous reset in the middle of a pulse, away from any edge.
    @(negedge clock);
    echo = 1'b1;
    repeat (7) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("areset_medida", 32'(medida), 32'h000);
    check("areset_pronto", 32'(pronto), 32'h0);
    check("areset_estado", 32'(db_estado), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    echo  = 1'b0;
    repeat (20) @(negedge clock);
    check("post_reset_estado", 32'(db_estado), 32'h1);
    check("post_reset_medida", 32'(medida), 32'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
